// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg                                                              |
// | Shared datapath widths and memory-port state encoding.               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mdr_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdr_mem_port                                                         |
// | MAR/MDR holding stage with a bounded req/ack memory handshake.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mdr_mem_port #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              rd_start,
    input  logic              wr_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import cpu_pkg::mem_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::RD_WAIT;
    import cpu_pkg::WR_WAIT;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] c_waitMax = CNT_W'(WAIT_MAX);

    mem_state_t        r_state, w_stateNext;
    logic [ADDR_W-1:0] r_mar, w_marNext;
    logic [ADDR_W-1:0] r_txnAddr, w_txnAddrNext;
    logic [DATA_W-1:0] r_mdr, w_mdrNext;
    logic [CNT_W-1:0]  r_waitCnt, w_waitCntNext;
    logic              r_req, w_reqNext;
    logic              r_we, w_weNext;
    logic              r_done, w_doneNext;
    logic              r_err, w_errNext;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mar     <= '0;
            r_txnAddr <= '0;
            r_mdr     <= '0;
            r_waitCnt <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_mar     <= w_marNext;
            r_txnAddr <= w_txnAddrNext;
            r_mdr     <= w_mdrNext;
            r_waitCnt <= w_waitCntNext;
            r_req     <= w_reqNext;
            r_we      <= w_weNext;
            r_done    <= w_doneNext;
            r_err     <= w_errNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_marNext     = r_mar;
        w_txnAddrNext = r_txnAddr;
        w_mdrNext     = r_mdr;
        w_waitCntNext = r_waitCnt;
        w_reqNext     = r_req;
        w_weNext      = r_we;
        w_doneNext    = 1'b0;
        w_errNext     = r_err;
        case (r_state)
            IDLE: begin
                if (mar_in) w_marNext = bus_in[ADDR_W-1:0];
                if (mdr_in) w_mdrNext = bus_in;
                // The transaction latches the pre-load MAR so a simultaneous load targets the next one.
                if (rd_start || wr_start) begin
                    w_stateNext   = rd_start ? RD_WAIT : WR_WAIT;
                    w_txnAddrNext = r_mar;
                    w_reqNext     = 1'b1;
                    w_weNext      = ~rd_start;
                    w_waitCntNext = '0;
                    w_errNext     = 1'b0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || (r_waitCnt == c_waitMax)) begin
                    if (mem_ack && (r_state == RD_WAIT)) w_mdrNext = mem_rdata;
                    if (!mem_ack) w_errNext = 1'b1;
                    w_stateNext = IDLE;
                    w_reqNext   = 1'b0;
                    w_weNext    = 1'b0;
                    w_doneNext  = 1'b1;
                end else begin
                    w_waitCntNext = r_waitCnt + 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign mem_addr  = busy ? r_txnAddr : r_mar;
    assign mem_wdata = r_mdr;
    assign mdr_out   = r_mdr;
    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mdr_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mdr_mem_port                                                      |
// | Directed + randomized transaction-level bench for mdr_mem_port.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mdr_mem_port;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int WMAX = 15;

    logic          clk = 1'b0;
    logic          clr;
    logic [DW-1:0] bus_in;
    logic          mar_in, mdr_in, rd_start, wr_start;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, mdr_out;
    logic          mem_req, mem_we, mem_ack, busy, done, err;

    int nChecks = 0;
    int nFail   = 0;

    logic [AW-1:0] mMar;
    logic [DW-1:0] mMdr;
    logic          mErr;

    mdr_mem_port #(.DATA_W(DW), .ADDR_W(AW), .WAIT_MAX(WMAX)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .rd_start(rd_start), .wr_start(wr_start), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_ack(mem_ack), .mdr_out(mdr_out), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        rd_start = 0; wr_start = 0; mar_in = 0; mdr_in = 0; mem_ack = 0;
    endtask

    task automatic idleLoad(input bit ldMar, input bit ldMdr, input logic [DW-1:0] v);
        mar_in = ldMar; mdr_in = ldMdr; bus_in = v;
        tick();
        idleInputs();
        if (ldMar) mMar = v[AW-1:0];
        if (ldMdr) mMdr = v;
        chk("load_addr", 64'(mem_addr), 64'(mMar));
        chk("load_mdr", 64'(mdr_out), 64'(mMdr));
        chk("load_busy", 64'(busy), 64'(0));
        chk("load_done", 64'(done), 64'(0));
    endtask

    // noise: 0 quiet, 1 random ignored inputs, 2 forced mdr_in=5 + rd_start while busy
    task automatic txn(input bit rd, input bit wr, input bit ldMar, input bit ldMdr,
                       input logic [DW-1:0] busVal, input int ackK,
                       input logic [DW-1:0] rdata, input int noise);
        bit            isRead;
        logic [AW-1:0] addrUsed;
        isRead = rd;
        rd_start = rd; wr_start = wr; mar_in = ldMar; mdr_in = ldMdr; bus_in = busVal;
        tick();
        idleInputs();
        addrUsed = mMar;
        if (ldMdr) mMdr = busVal;
        if (ldMar) mMar = busVal[AW-1:0];
        mErr = 0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_req", 64'(mem_req), 64'(1));
        chk("start_we", 64'(mem_we), 64'(!isRead));
        chk("start_done", 64'(done), 64'(0));
        chk("start_err", 64'(err), 64'(0));
        chk("start_addr", 64'(mem_addr), 64'(addrUsed));
        chk("start_wdata", 64'(mem_wdata), 64'(mMdr));
        for (int j = 0; j <= WMAX; j++) begin
            mem_ack   = (j == ackK);
            mem_rdata = (j == ackK) ? rdata : DW'($urandom);
            if (noise == 1) begin
                rd_start = 1'($urandom); wr_start = 1'($urandom);
                mar_in = 1'($urandom); mdr_in = 1'($urandom); bus_in = DW'($urandom);
            end else if (noise == 2) begin
                rd_start = 1; mdr_in = 1; bus_in = 32'h5;
            end
            tick();
            idleInputs();
            if (j == ackK || j == WMAX) begin
                if (j == ackK && isRead) mMdr = rdata;
                if (j != ackK) mErr = 1;
                chk("end_done", 64'(done), 64'(1));
                chk("end_busy", 64'(busy), 64'(0));
                chk("end_req", 64'(mem_req), 64'(0));
                chk("end_we", 64'(mem_we), 64'(0));
                chk("end_err", 64'(err), 64'(mErr));
                chk("end_mdr", 64'(mdr_out), 64'(mMdr));
                chk("end_addr", 64'(mem_addr), 64'(mMar));
                break;
            end
            chk("wait_busy", 64'(busy), 64'(1));
            chk("wait_req", 64'(mem_req), 64'(1));
            chk("wait_done", 64'(done), 64'(0));
            chk("wait_addr", 64'(mem_addr), 64'(addrUsed));
            chk("wait_mdr", 64'(mdr_out), 64'(mMdr));
        end
    endtask

    initial begin
        clr = 1; bus_in = '0; mem_rdata = '0;
        idleInputs();
        mMar = '0; mMdr = '0; mErr = 0;
        #1;
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_mdr", 64'(mdr_out), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_flags", 64'({busy, done, err, mem_we}), 64'(0));
        tick();
        clr = 0;
        tick();

        // Zero-wait read
        idleLoad(1, 0, 32'h0000_0012);
        txn(1, 0, 0, 0, 32'h0, 0, 32'h002C_3003, 0);
        chk("rd0_addr_val", 64'(mem_addr), 64'h012);

        // Write with 3 wait cycles
        idleLoad(0, 1, 32'hDEAD_BEEF);
        idleLoad(1, 0, 32'h0000_01FF);
        txn(0, 1, 0, 0, 32'h0, 3, 32'h1234_5678, 0);
        chk("wr_mdr_kept", 64'(mdr_out), 64'hDEAD_BEEF);

        // Timeout, then err cleared by next start; back-to-back after done
        txn(1, 0, 0, 0, 32'h0, -1, 32'h0, 1);
        chk("to_err", 64'(err), 64'(1));
        txn(1, 0, 0, 0, 32'h0, 2, 32'hCAFE_0001, 0);

        // Ack on the last allowed wait cycle
        txn(1, 0, 0, 0, 32'h0, WMAX, 32'h0BAD_F00D, 0);

        // Read+write collision, with mdr_in=5 and rd_start while busy
        txn(1, 1, 0, 0, 32'h0, 4, 32'h7777_0000, 2);
        // mdr_in with rd_start, mar_in with start
        txn(1, 0, 1, 1, 32'h1357_90AB, 1, 32'h2468_ACE0, 0);
        txn(0, 1, 1, 1, 32'hFEED_0042, 0, 32'h0, 0);

        // Ack while idle is ignored
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        idleInputs();
        chk("idle_ack_mdr", 64'(mdr_out), 64'(mMdr));
        chk("idle_ack_done", 64'(done), 64'(0));

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            int  k;
            bit  r;
            r = 1'($urandom);
            k = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, WMAX));
            if ($urandom_range(0, 2) == 0) idleLoad(1'($urandom), 1'($urandom), DW'($urandom));
            txn(r, !r || 1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
                k, DW'($urandom), int'($urandom_range(0, 1)));
        end

        // Asynchronous clear in the middle of a read
        idleLoad(1, 1, 32'hA5A5_0123);
        rd_start = 1;
        tick();
        idleInputs();
        tick();
        tick();
        chk("pre_clr_req", 64'(mem_req), 64'(1));
        #2 clr = 1;
        #1;
        mMar = '0; mMdr = '0; mErr = 0;
        chk("clr_req", 64'(mem_req), 64'(0));
        chk("clr_busy", 64'(busy), 64'(0));
        chk("clr_mdr", 64'(mdr_out), 64'(0));
        chk("clr_addr", 64'(mem_addr), 64'(0));
        chk("clr_flags", 64'({done, err, mem_we}), 64'(0));
        tick();
        clr = 0;
        tick();
        txn(0, 1, 0, 0, 32'h0, 2, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
